// File: rtl/register_file_mp.sv
// Multi-port register file with per-register busy scoreboard and optional write-to-read bypass.
// Register 0 reads as zero and is never marked busy.
module register_file_mp #(
  parameter int unsigned N       = 6,
  parameter int unsigned M       = 32,
  parameter int unsigned NR      = 2,
  parameter int unsigned NW      = 2,
  parameter int unsigned SYNC_RD = 0,
  parameter int unsigned BYPASS  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NR*N-1:0] raddr,
  output logic [NR*M-1:0] rdata,
  output logic [NR-1:0]   rbusy,
  input  logic [NW-1:0]   we,
  input  logic [NW*N-1:0] waddr,
  input  logic [NW*M-1:0] wdata,
  input  logic            alloc_en,
  input  logic [N-1:0]    alloc_addr,
  output logic            alloc_stall
);

  localparam int unsigned DEPTH = 2**N;

  logic [M-1:0]     r_mem [DEPTH];
  logic [DEPTH-1:0] r_busy;

  logic [DEPTH-1:0] w_wr_hit;
  logic [DEPTH-1:0] w_busy_nxt;
  logic [M-1:0]     w_rd_data [NR];
  logic [NR-1:0]    w_rd_busy;

  // Storage: later write ports overwrite earlier ones on the same address.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      for (int w = 0; w < NW; w++) begin
        if (we[w] && (waddr[w*N +: N] != '0)) r_mem[waddr[w*N +: N]] <= wdata[w*M +: M];
      end
    end
  end

  always_comb begin
    w_wr_hit = '0;
    for (int w = 0; w < NW; w++) begin
      if (we[w]) w_wr_hit[waddr[w*N +: N]] = 1'b1;
    end
  end

  // A pending write to the allocated register lets the new producer take it over.
  assign alloc_stall = alloc_en & r_busy[alloc_addr] & ~w_wr_hit[alloc_addr];

  always_comb begin
    w_busy_nxt = r_busy & ~w_wr_hit;
    if (alloc_en && !alloc_stall) w_busy_nxt[alloc_addr] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_busy <= '0;
    else        r_busy <= w_busy_nxt;
  end

  // Read view; with bypass this is also the write-first value seen at the next edge.
  always_comb begin
    for (int r = 0; r < NR; r++) begin
      w_rd_data[r] = r_mem[raddr[r*N +: N]];
      w_rd_busy[r] = r_busy[raddr[r*N +: N]];
      if (BYPASS != 0) begin
        for (int w = 0; w < NW; w++) begin
          if (we[w] && (waddr[w*N +: N] == raddr[r*N +: N])) begin
            w_rd_data[r] = wdata[w*M +: M];
            w_rd_busy[r] = 1'b0;
          end
        end
      end
      if (raddr[r*N +: N] == '0) begin
        w_rd_data[r] = '0;
        w_rd_busy[r] = 1'b0;
      end
    end
  end

  if (SYNC_RD != 0) begin : g_sync
    logic [M-1:0]  r_rd_data [NR];
    logic [NR-1:0] r_rd_busy;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int r = 0; r < NR; r++) r_rd_data[r] <= '0;
        r_rd_busy <= '0;
      end else begin
        for (int r = 0; r < NR; r++) r_rd_data[r] <= w_rd_data[r];
        r_rd_busy <= w_rd_busy;
      end
    end

    always_comb begin
      for (int r = 0; r < NR; r++) rdata[r*M +: M] = r_rd_data[r];
      rbusy = r_rd_busy;
    end
  end else begin : g_comb
    always_comb begin
      for (int r = 0; r < NR; r++) rdata[r*M +: M] = w_rd_data[r];
      rbusy = w_rd_busy;
    end
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: four read/bypass configurations driven in lockstep,
// checked against an array-based reference model.
module tb_register_file_mp;

  localparam int unsigned N  = 6;
  localparam int unsigned M  = 32;
  localparam int unsigned NR = 2;
  localparam int unsigned NW = 2;
  localparam int unsigned DEPTH = 2**N;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR*N-1:0] raddr;
  logic [NW-1:0]   we;
  logic [NW*N-1:0] waddr;
  logic [NW*M-1:0] wdata;
  logic            alloc_en;
  logic [N-1:0]    alloc_addr;

  // a: comb+bypass, b: comb no bypass, s: sync+bypass, t: sync no bypass
  logic [NR*M-1:0] rdata_a, rdata_b, rdata_s, rdata_t;
  logic [NR-1:0]   rbusy_a, rbusy_b, rbusy_s, rbusy_t;
  logic            stall_a, stall_b, stall_s, stall_t;

  int errors = 0;
  int checks = 0;

  logic [M-1:0] m_mem [DEPTH];
  logic         m_busy [DEPTH];
  bit           model_valid = 1'b0;
  logic [M-1:0] exp_s_d [NR];
  logic         exp_s_b [NR];
  logic [M-1:0] exp_t_d [NR];
  logic         exp_t_b [NR];

  always #5 clk = ~clk;

  register_file_mp #(.N(N), .M(M), .NR(NR), .NW(NW), .SYNC_RD(0), .BYPASS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata_a), .rbusy(rbusy_a), .we(we),
    .waddr(waddr), .wdata(wdata), .alloc_en(alloc_en), .alloc_addr(alloc_addr), .alloc_stall(stall_a));
  register_file_mp #(.N(N), .M(M), .NR(NR), .NW(NW), .SYNC_RD(0), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b), .we(we),
    .waddr(waddr), .wdata(wdata), .alloc_en(alloc_en), .alloc_addr(alloc_addr), .alloc_stall(stall_b));
  register_file_mp #(.N(N), .M(M), .NR(NR), .NW(NW), .SYNC_RD(1), .BYPASS(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata_s), .rbusy(rbusy_s), .we(we),
    .waddr(waddr), .wdata(wdata), .alloc_en(alloc_en), .alloc_addr(alloc_addr), .alloc_stall(stall_s));
  register_file_mp #(.N(N), .M(M), .NR(NR), .NW(NW), .SYNC_RD(1), .BYPASS(0)) dut_t (
    .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata_t), .rbusy(rbusy_t), .we(we),
    .waddr(waddr), .wdata(wdata), .alloc_en(alloc_en), .alloc_addr(alloc_addr), .alloc_stall(stall_t));

  task automatic check(input string tag, input logic [M-1:0] obs, input logic [M-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit write_to(input logic [N-1:0] a);
    bit hit = 1'b0;
    for (int w = 0; w < NW; w++) if (we[w] && waddr[w*N +: N] == a) hit = 1'b1;
    return hit;
  endfunction

  // What a reader sees for address a, with or without same-cycle forwarding.
  task automatic model_read(input logic [N-1:0] a, input bit byp, output logic [M-1:0] d, output logic b);
    d = m_mem[a];
    b = m_busy[a];
    if (byp) begin
      for (int w = 0; w < NW; w++) begin
        if (we[w] && waddr[w*N +: N] == a) begin
          d = wdata[w*M +: M];
          b = 1'b0;
        end
      end
    end
    if (a == '0) begin
      d = '0;
      b = 1'b0;
    end
  endtask

  function automatic logic model_stall();
    return alloc_en && (alloc_addr != '0) && m_busy[alloc_addr] && !write_to(alloc_addr);
  endfunction

  task automatic model_update();
    logic st;
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[i]  = '0;
        m_busy[i] = 1'b0;
      end
      model_valid = 1'b1;
    end else begin
      st = model_stall();
      for (int w = 0; w < NW; w++) begin
        if (we[w] && waddr[w*N +: N] != '0) m_mem[waddr[w*N +: N]] = wdata[w*M +: M];
        if (we[w]) m_busy[waddr[w*N +: N]] = 1'b0;
      end
      if (alloc_en && !st && alloc_addr != '0) m_busy[alloc_addr] = 1'b1;
    end
  endtask

  // One clock: comb outputs checked before the edge, sync outputs just after it.
  task automatic step();
    logic [M-1:0] ed;
    logic         eb;
    bit           sync_chk;
    @(negedge clk);
    if (model_valid) begin
      for (int r = 0; r < NR; r++) begin
        model_read(raddr[r*N +: N], 1'b1, ed, eb);
        check("a_rdata", rdata_a[r*M +: M], ed);
        check("a_rbusy", M'(rbusy_a[r]), M'(eb));
        model_read(raddr[r*N +: N], 1'b0, ed, eb);
        check("b_rdata", rdata_b[r*M +: M], ed);
        check("b_rbusy", M'(rbusy_b[r]), M'(eb));
      end
      check("a_stall", M'(stall_a), M'(model_stall()));
      check("b_stall", M'(stall_b), M'(model_stall()));
      check("s_stall", M'(stall_s), M'(model_stall()));
      check("t_stall", M'(stall_t), M'(model_stall()));
    end
    sync_chk = !rst_n || model_valid;
    for (int r = 0; r < NR; r++) begin
      model_read(raddr[r*N +: N], 1'b1, exp_s_d[r], exp_s_b[r]);
      model_read(raddr[r*N +: N], 1'b0, exp_t_d[r], exp_t_b[r]);
      if (!rst_n) begin
        exp_s_d[r] = '0; exp_s_b[r] = 1'b0;
        exp_t_d[r] = '0; exp_t_b[r] = 1'b0;
      end
    end
    @(posedge clk);
    model_update();
    #1;
    if (sync_chk) begin
      for (int r = 0; r < NR; r++) begin
        check("s_rdata", rdata_s[r*M +: M], exp_s_d[r]);
        check("s_rbusy", M'(rbusy_s[r]), M'(exp_s_b[r]));
        check("t_rdata", rdata_t[r*M +: M], exp_t_d[r]);
        check("t_rbusy", M'(rbusy_t[r]), M'(exp_t_b[r]));
      end
    end
  endtask

  task automatic set_wr(input int w, input logic en, input logic [N-1:0] a, input logic [M-1:0] d);
    we[w] = en;
    waddr[w*N +: N] = a;
    wdata[w*M +: M] = d;
  endtask

  task automatic set_rd(input logic [N-1:0] a0, input logic [N-1:0] a1);
    raddr[0 +: N] = a0;
    raddr[N +: N] = a1;
  endtask

  task automatic idle();
    we = '0;
    alloc_en = 1'b0;
    alloc_addr = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    raddr = '0;
    waddr = '0;
    wdata = '0;
    idle();
    step();
    step();
    rst_n = 1'b1;

    // Reset contents on every port
    for (int a = 0; a < DEPTH; a++) begin
      set_rd(N'(a), N'(DEPTH - 1 - a));
      step();
    end

    // Same-address collision: higher port wins
    set_wr(0, 1'b1, 6'd5, 32'hDEAD_BEEF);
    set_wr(1, 1'b1, 6'd5, 32'h1234_5678);
    step();
    idle();
    set_rd(6'd5, 6'd5);
    #1;
    check("collide_p0", rdata_a[0 +: M], 32'h1234_5678);
    check("collide_p1", rdata_b[M +: M], 32'h1234_5678);
    step();

    // Register zero ignores writes and allocation
    set_wr(0, 1'b1, 6'd0, 32'hFFFF_FFFF);
    set_rd(6'd0, 6'd0);
    alloc_en = 1'b1;
    alloc_addr = 6'd0;
    step();
    idle();
    #1;
    check("zero_data", rdata_a[0 +: M], 32'h0);
    check("zero_busy", M'(rbusy_a[0]), 32'h0);
    alloc_en = 1'b1;
    #1;
    check("zero_stall", M'(stall_a), 32'h0);
    step();
    idle();

    // Same-cycle forwarding versus stored value
    set_wr(0, 1'b1, 6'd9, 32'hA5A5_A5A5);
    set_rd(6'd9, 6'd5);
    #1;
    check("byp_new", rdata_a[0 +: M], 32'hA5A5_A5A5);
    check("nobyp_old", rdata_b[0 +: M], 32'h0);
    step();
    idle();
    #1;
    check("nobyp_next", rdata_b[0 +: M], 32'hA5A5_A5A5);
    step();

    // Scoreboard on register 7
    alloc_en = 1'b1;
    alloc_addr = 6'd7;
    set_rd(6'd7, 6'd7);
    step();
    #1;
    check("alloc_busy", M'(rbusy_a[0]), 32'h1);
    check("alloc_stall", M'(stall_a), 32'h1);
    step();
    set_wr(1, 1'b1, 6'd7, 32'h0000_0077);
    #1;
    check("wr_alloc_nostall", M'(stall_a), 32'h0);
    step();
    idle();
    #1;
    check("wr_alloc_busy", M'(rbusy_a[0]), 32'h1);
    step();
    set_wr(0, 1'b1, 6'd7, 32'h0000_0777);
    step();
    idle();
    #1;
    check("wr_clears_busy", M'(rbusy_b[0]), 32'h0);
    step();

    // Reset dominates a concurrent write (sync read path)
    set_wr(0, 1'b1, 6'd3, 32'h0000_0033);
    step();
    rst_n = 1'b0;
    set_wr(0, 1'b1, 6'd3, 32'hCAFE_F00D);
    set_rd(6'd3, 6'd3);
    step();
    step();
    rst_n = 1'b1;
    idle();
    step();
    check("rst_sync_rd", rdata_s[0 +: M], 32'h0);
    check("rst_sync_rd_t", rdata_t[M +: M], 32'h0);

    // Random traffic on a narrow address window to provoke collisions
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 79) != 0);
      for (int w = 0; w < NW; w++)
        set_wr(w, 1'($urandom_range(0, 1)), N'($urandom_range(0, 15)), $urandom());
      alloc_en = 1'($urandom_range(0, 1));
      alloc_addr = N'($urandom_range(0, 15));
      set_rd(N'($urandom_range(0, 15)), N'($urandom_range(0, 15)));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
